mem_port_arb: RTL and testbench
===============================

# mem_port_arb

Arbiter and sequencer that lets the fetch stage (IF) and the memory stage (MEM) of the RV32 pipeline share one unified memory bus port. It accepts one request from each stage, grants one at a time with MEM priority plus an IF starvation guard, drives a single outstanding bus transaction through a request/grant/response handshake, and returns read data and a completion pulse to the owning stage. It also generates per-stage stall signals for the hazard/pipeline control logic.

## Interface
- STARVE_MAX, 4: consecutive IF losses after which IF wins the next contested arbitration (1..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  IF read request; held with if_addr stable until if_valid
- if_addr  in  32  fetch address
- if_rdata  out  32  fetch data, valid while if_valid
- if_valid  out  1  one-cycle completion pulse for IF
- if_stall  out  1  if_req & ~if_valid (combinational)
- mem_req  in  1  MEM request; mem_we/be/addr/wdata held stable until mem_valid
- mem_we  in  1  1 = store, 0 = load
- mem_be  in  4  byte enables (stores)
- mem_addr  in  32  data address
- mem_wdata  in  32  store data
- mem_rdata  out  32  load data, valid while mem_valid
- mem_valid  out  1  one-cycle completion pulse for MEM (loads and stores)
- mem_stall  out  1  mem_req & ~mem_valid (combinational)
- bus_req  out  1  transaction request to memory
- bus_we, bus_be, bus_addr, bus_wdata  out  1/4/32/32  latched fields of granted request
- bus_gnt  in  1  memory accepts request this cycle
- bus_rvalid  in  1  response (read data or write ack)
- bus_rdata  in  32  response data
- perf_conflict_cnt  out  32  contested-arbitration counter
- perf_busy_cnt  out  32  bus-occupied cycle counter
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.

## Operation
- FSM states: IDLE, REQ (bus_req=1, awaiting bus_gnt), RSP (awaiting bus_rvalid).
- IDLE: eligible requester = req high and its own _valid not high this cycle. None eligible -> stay IDLE. Otherwise latch owner, we (0 for IF), be (4'b1111 for IF), addr, wdata (0 for IF) -> REQ.
- Arbitration: only MEM eligible -> MEM; only IF -> IF; both -> MEM unless starve_cnt == STARVE_MAX, then IF.
- starve_cnt (4 bit): +1 (saturating at STARVE_MAX) when MEM is granted while IF eligible; cleared when IF is granted; unchanged otherwise.
- REQ: bus_req=1 with latched fields; bus_gnt=1 -> RSP. bus_rvalid ignored in REQ.
- RSP: bus_req=0; bus_rvalid=1 -> register bus_rdata into owner's _rdata, pulse owner's _valid next cycle, -> IDLE.
- bus_rvalid in IDLE ignored (stray response dropped).
- Stores also complete via bus_rvalid; mem_rdata then carries whatever bus_rdata held (don't-care).
- _rdata outputs hold last value between pulses.

## Timing
- Reset values: state IDLE, starve_cnt 0, bus_req 0, bus_we 0, bus_be 0, bus_addr 0, bus_wdata 0, if_valid 0, mem_valid 0, if_rdata 0, mem_rdata 0, perf counters 0.
- Minimum latency: req sampled in IDLE at cycle 0 -> bus_req=1 cycle 1 -> (gnt cycle 1) RSP cycle 2 -> (rvalid cycle 2) _valid=1 cycle 3.
- Back-to-back throughput: one transaction per 3 cycles minimum; _valid cycle coincides with IDLE, so the completing requester is ineligible that cycle, the other may be granted.
- Reset mid-transaction: state -> IDLE next edge, no _valid pulse for the dropped transaction; subsequent stray bus_rvalid ignored.
- bus_* fields change only on the IDLE->REQ edge.

## Configuration
- ARB_PERF_CNT_EN defined: perf_conflict_cnt +1 each IDLE cycle where both requesters eligible; perf_busy_cnt +1 each cycle state != IDLE; both wrap modulo 2^32, reset to 0.
- Not defined: counters not instantiated, both ports tied to 32'h0; all other behaviour identical.

## Test plan
- Single IF read: if_req=1, addr 0x100, bus_gnt immediate, bus_rvalid cycle 2 with 0x00500093 -> if_valid cycle 3, if_rdata=0x00500093, if_stall 1 in cycles 0-2, 0 in 3.
- Store: mem_req, we=1, be=4'b0011, addr 0x2004, wdata 0xDEADBEEF; gnt delayed 3 cycles -> bus_req high 4 cycles, bus fields exactly those values, mem_valid one cycle after rvalid.
- Contention: if_req and mem_req held continuously -> grant order MEM×4, IF, MEM×4, IF (STARVE_MAX=4); perf_conflict_cnt counts each contested IDLE cycle (with ARB_PERF_CNT_EN).
- Stray/early response: bus_rvalid pulsed in IDLE and in REQ before gnt -> no _valid pulse, state unaffected.
- Reset in RSP: rst one cycle while awaiting rvalid -> all outputs reset values next cycle, later rvalid ignored, fresh if_req then completes normally with 3-cycle latency.
- Without ARB_PERF_CNT_EN: contention run -> perf_conflict_cnt and perf_busy_cnt stay 0.

Source files
------------

// File: rtl/mem_port_arb_if.sv
// mem_port_arb_if: the IF fetch port, MEM data port, unified memory bus
// and perf counters of mem_port_arb, grouped as one bundle.
// master = arbiter side, slave = pipeline/memory side.
interface mem_port_arb_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic [31:0] perf_conflict_cnt;
  logic [31:0] perf_busy_cnt;

  modport master (
    input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           bus_gnt, bus_rvalid, bus_rdata,
    output if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           bus_req, bus_we, bus_be, bus_addr, bus_wdata,
           perf_conflict_cnt, perf_busy_cnt
  );

  modport slave (
    output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata,
           bus_gnt, bus_rvalid, bus_rdata,
    input  if_rdata, if_valid, if_stall, mem_rdata, mem_valid, mem_stall,
           bus_req, bus_we, bus_be, bus_addr, bus_wdata,
           perf_conflict_cnt, perf_busy_cnt
  );
endinterface

// File: rtl/mem_port_arb.sv
// mem_port_arb: shares one memory bus port between the IF and MEM stages.
// One outstanding transaction (IDLE -> REQ -> RSP), MEM priority with an
// IF starvation guard after STARVE_MAX consecutive contested IF losses.
// Optional macro ARB_PERF_CNT_EN adds contested-arbitration and
// bus-busy counters; without it both perf outputs are tied to zero.
module mem_port_arb #(
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_port_arb_if.master p
);
  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  typedef struct packed {
    logic        owner_mem;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_cmd_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state, state_nxt;
  bus_cmd_t    cmd, cmd_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic        if_valid_q, mem_valid_q;
  logic [31:0] if_rdata_q, mem_rdata_q;
  logic        if_elig, mem_elig, rsp_done;

  // A requester completing this cycle is still holding req; it must not be re-granted.
  assign if_elig  = p.if_req  & ~if_valid_q;
  assign mem_elig = p.mem_req & ~mem_valid_q;

  // Next state, arbitration and command capture; cmd only moves on IDLE->REQ.
  always_comb begin
    state_nxt  = state;
    cmd_nxt    = cmd;
    starve_nxt = starve_cnt;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_elig && !(if_elig && starve_cnt == STARVE_LIM)) begin
          cmd_nxt   = '{owner_mem: 1'b1, we: p.mem_we, be: p.mem_be,
                        addr: p.mem_addr, wdata: p.mem_wdata};
          state_nxt = REQ;
          if (if_elig && starve_cnt < STARVE_LIM) starve_nxt = starve_cnt + 4'd1;
        end else if (if_elig) begin
          cmd_nxt    = '{owner_mem: 1'b0, we: 1'b0, be: 4'b1111,
                         addr: p.if_addr, wdata: 32'h0};
          state_nxt  = REQ;
          starve_nxt = 4'd0;
        end
      end
      REQ: if (p.bus_gnt) state_nxt = RSP;
      RSP: begin
        if (p.bus_rvalid) begin
          rsp_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched command, starvation counter and response return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd         <= '0;
      starve_cnt  <= 4'd0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_rdata_q  <= 32'h0;
      mem_rdata_q <= 32'h0;
    end else begin
      state       <= state_nxt;
      cmd         <= cmd_nxt;
      starve_cnt  <= starve_nxt;
      if_valid_q  <= rsp_done & ~cmd.owner_mem;
      mem_valid_q <= rsp_done &  cmd.owner_mem;
      if (rsp_done && !cmd.owner_mem) if_rdata_q  <= p.bus_rdata;
      if (rsp_done &&  cmd.owner_mem) mem_rdata_q <= p.bus_rdata;
    end
  end

  assign p.bus_req   = (state == REQ);
  assign p.bus_we    = cmd.we;
  assign p.bus_be    = cmd.be;
  assign p.bus_addr  = cmd.addr;
  assign p.bus_wdata = cmd.wdata;
  assign p.if_valid  = if_valid_q;
  assign p.mem_valid = mem_valid_q;
  assign p.if_rdata  = if_rdata_q;
  assign p.mem_rdata = mem_rdata_q;
  assign p.if_stall  = p.if_req  & ~if_valid_q;
  assign p.mem_stall = p.mem_req & ~mem_valid_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt, busy_cnt;

  // Contested IDLE cycles and non-IDLE cycles; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= 32'h0;
      busy_cnt     <= 32'h0;
    end else begin
      if (state == IDLE && if_elig && mem_elig) conflict_cnt <= conflict_cnt + 32'd1;
      if (state != IDLE) busy_cnt <= busy_cnt + 32'd1;
    end
  end

  assign p.perf_conflict_cnt = conflict_cnt;
  assign p.perf_busy_cnt     = busy_cnt;
`else
  assign p.perf_conflict_cnt = 32'h0;
  assign p.perf_busy_cnt     = 32'h0;
`endif
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: scoreboard bench for mem_port_arb. Expected read data
// and expected bus commands are queued when requests are driven and
// checked when the DUT grants / completes. A behavioural memory answers
// the bus, or the sequence drives the bus by hand for corner cases.
module tb_mem_port_arb;
  logic clk, rst;
  mem_port_arb_if bus_if();

  mem_port_arb #(.STARVE_MAX(4)) dut (.clk(clk), .rst(rst), .p(bus_if.master));

  // stimulus variables
  logic        if_want, mem_want, arb_mask;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic        resp_en;
  logic        man_gnt, man_rv;
  logic [31:0] man_rdata;
  logic        rsp_gnt, rsp_rv;
  logic [31:0] rsp_rdata;
  int          gnt_dly;

  // arb_mask drops a requester during the other's completion cycle so that
  // every grant in the contention run is a contested one
  assign bus_if.if_req     = if_want  & ~(arb_mask & bus_if.mem_valid);
  assign bus_if.mem_req    = mem_want & ~(arb_mask & bus_if.if_valid);
  assign bus_if.if_addr    = if_addr;
  assign bus_if.mem_we     = mem_we;
  assign bus_if.mem_be     = mem_be;
  assign bus_if.mem_addr   = mem_addr;
  assign bus_if.mem_wdata  = mem_wdata;
  assign bus_if.bus_gnt    = resp_en ? rsp_gnt   : man_gnt;
  assign bus_if.bus_rvalid = resp_en ? rsp_rv    : man_rv;
  assign bus_if.bus_rdata  = resp_en ? rsp_rdata : man_rdata;

  typedef struct packed { logic chk; logic [31:0] d; } mexp_t;
  logic [31:0] if_q[$];
  mexp_t       mem_q[$];
  logic [68:0] gnt_q[$];   // {we, be, addr, wdata}
  int checks, errors, n_done;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // behavioural memory: grant after gnt_dly REQ cycles, respond the next cycle
  initial begin : responder
    logic        taken;
    logic [31:0] taddr;
    int          wait_cnt;
    taken = 1'b0; taddr = '0; wait_cnt = 0;
    rsp_gnt = 1'b0; rsp_rv = 1'b0; rsp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        rsp_rv  = 1'b0;
        rsp_gnt = 1'b0;
        if (taken) begin
          rsp_rv    = 1'b1;
          rsp_rdata = rd_model(taddr);
          taken     = 1'b0;
        end
        if (bus_if.bus_req) begin
          if (wait_cnt >= gnt_dly) begin
            rsp_gnt  = 1'b1;
            taken    = 1'b1;
            taddr    = bus_if.bus_addr;
            wait_cnt = 0;
          end else wait_cnt++;
        end
      end
    end
  end

  // scoreboard: bus command at grant, read data at completion
  initial begin : monitor
    logic [31:0] e;
    mexp_t       m;
    logic [68:0] g;
    forever begin
      @(negedge clk); #2;
      if (bus_if.bus_req && bus_if.bus_gnt) begin
        if (gnt_q.size() == 0) chk("gnt_unexp", 1, 0);
        else begin
          g = gnt_q.pop_front();
          chk("bus_cmd", {bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr, bus_if.bus_wdata}, g);
        end
      end
      if (bus_if.if_valid) begin
        if (if_q.size() == 0) chk("if_valid_unexp", 1, 0);
        else begin
          e = if_q.pop_front();
          chk("if_rdata", bus_if.if_rdata, e);
        end
        n_done++;
      end
      if (bus_if.mem_valid) begin
        if (mem_q.size() == 0) chk("mem_valid_unexp", 1, 0);
        else begin
          m = mem_q.pop_front();
          if (m.chk) chk("mem_rdata", bus_if.mem_rdata, m.d);
        end
        n_done++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bus"}, {bus_if.bus_req, bus_if.bus_we, bus_if.bus_be, bus_if.bus_addr, bus_if.bus_wdata}, '0);
    chk({tag, "_valid"}, {bus_if.if_valid, bus_if.mem_valid}, '0);
    chk({tag, "_rdata"}, {bus_if.if_rdata, bus_if.mem_rdata}, '0);
    chk({tag, "_perf"}, {bus_if.perf_conflict_cnt, bus_if.perf_busy_cnt}, '0);
  endtask

  // IF read with immediate grant: checks the 3-cycle latency and stall shape
  task automatic if_read(input logic [31:0] a);
    @(negedge clk);
    if_want = 1'b1; if_addr = a;
    if_q.push_back(rd_model(a));
    gnt_q.push_back({1'b0, 4'hf, a, 32'h0});
    #1 chk("if_stall_c0", bus_if.if_stall, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("if_stall_c%0d", k), bus_if.if_stall, (k < 3));
      chk($sformatf("bus_req_c%0d", k), bus_if.bus_req, (k == 1));
      chk($sformatf("if_valid_c%0d", k), bus_if.if_valid, (k == 3));
    end
    if_want = 1'b0;
  endtask

  initial begin : main
    int nreq, rv_cyc, vl_cyc;
    logic [31:0] exp_conf, exp_busy;
    checks = 0; errors = 0; n_done = 0;
    rst = 1'b1; if_want = 0; mem_want = 0; arb_mask = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0; mem_we = 0; mem_be = '0;
    resp_en = 1'b1; man_gnt = 0; man_rv = 0; man_rdata = '0; gnt_dly = 0;
    do_reset();
    chk_reset_outputs("rst0");

    // single IF read
    if_read(32'h100);

    // store with grant delayed by 3 cycles
    @(negedge clk);
    gnt_dly = 3;
    mem_want = 1; mem_we = 1; mem_be = 4'b0011; mem_addr = 32'h2004; mem_wdata = 32'hDEADBEEF;
    mem_q.push_back('{chk: 1'b0, d: 32'h0});
    gnt_q.push_back({1'b1, 4'b0011, 32'h2004, 32'hDEADBEEF});
    nreq = 0; rv_cyc = -1; vl_cyc = -1;
    for (int k = 1; k <= 20 && vl_cyc < 0; k++) begin
      @(negedge clk);
      if (bus_if.bus_req) nreq++;
      if (bus_if.bus_rvalid) rv_cyc = k;
      if (bus_if.mem_valid) begin
        vl_cyc = k;
        chk("store_stall_done", bus_if.mem_stall, 1'b0);
        mem_want = 0;
      end else if (k == 1) chk("store_stall", bus_if.mem_stall, 1'b1);
    end
    chk("store_req_cycles", nreq, 4);
    chk("store_valid_after_rv", vl_cyc, rv_cyc + 1);
    chk("store_valid_cyc", vl_cyc, 6);
    gnt_dly = 0;

    // stray response in IDLE, early response in REQ
    @(negedge clk);
    resp_en = 0; man_gnt = 0; man_rv = 1; man_rdata = 32'h1111_1111;
    @(negedge clk);
    man_rv = 0;
    chk("stray_idle_valid", {bus_if.if_valid, bus_if.mem_valid}, 2'b00);
    if_want = 1; if_addr = 32'h200;
    if_q.push_back(rd_model(32'h200));
    gnt_q.push_back({1'b0, 4'hf, 32'h200, 32'h0});
    @(negedge clk);
    chk("early_req_c1", bus_if.bus_req, 1'b1);
    man_rv = 1; man_rdata = 32'h2222_2222;
    @(negedge clk);
    chk("early_req_c2", bus_if.bus_req, 1'b1);
    chk("early_no_valid", bus_if.if_valid, 1'b0);
    man_rv = 0; man_gnt = 1;
    @(negedge clk);
    chk("early_rsp_req", bus_if.bus_req, 1'b0);
    man_gnt = 0; man_rv = 1; man_rdata = rd_model(32'h200);
    @(negedge clk);
    chk("early_valid", bus_if.if_valid, 1'b1);
    man_rv = 0; if_want = 0;
    @(negedge clk);
    resp_en = 1;

    // reset while awaiting the response
    @(negedge clk);
    resp_en = 0;
    mem_want = 1; mem_we = 0; mem_be = 4'hf; mem_addr = 32'h300; mem_wdata = 32'h0;
    gnt_q.push_back({1'b0, 4'hf, 32'h300, 32'h0});
    @(negedge clk);
    man_gnt = 1;
    @(negedge clk);
    man_gnt = 0; rst = 1; mem_want = 0;
    @(negedge clk);
    rst = 0;
    chk_reset_outputs("rst_rsp");
    man_rv = 1; man_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    man_rv = 0;
    @(negedge clk);
    chk("rst_rsp_no_valid", {bus_if.if_valid, bus_if.mem_valid}, 2'b00);
    resp_en = 1;
    if_read(32'h400);

    // contention with starvation guard: M x4, I, M x4, I
    do_reset();
    @(negedge clk);
    arb_mask = 1; mem_we = 0; mem_be = 4'hf; mem_addr = 32'h800; mem_wdata = 32'h0; if_addr = 32'h900;
    for (int g = 0; g < 10; g++) begin
      if (g == 4 || g == 9) begin
        if_q.push_back(rd_model(32'h900));
        gnt_q.push_back({1'b0, 4'hf, 32'h900, 32'h0});
      end else begin
        mem_q.push_back('{chk: 1'b1, d: rd_model(32'h800)});
        gnt_q.push_back({1'b0, 4'hf, 32'h800, 32'h0});
      end
    end
    n_done = 0;
    if_want = 1; mem_want = 1;
    for (int k = 0; k < 300 && n_done < 10; k++) begin
      @(negedge clk); #3;
    end
    if_want = 0; mem_want = 0; arb_mask = 0;
    chk("cont_done", n_done, 10);
    @(negedge clk);
    @(negedge clk);
`ifdef ARB_PERF_CNT_EN
    exp_conf = 32'd10; exp_busy = 32'd20;
`else
    exp_conf = 32'd0;  exp_busy = 32'd0;
`endif
    chk("perf_conflict", bus_if.perf_conflict_cnt, exp_conf);
    chk("perf_busy", bus_if.perf_busy_cnt, exp_busy);
    chk("queues_empty", if_q.size() + mem_q.size() + gnt_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
